eth_packet_player: RTL

Synthesizable, memory-backed Ethernet stimulus engine for the 64-bit AXI-stream network port of the shell debug design. It plays a preloaded sequence of packet flits onto the transmit stream. Each packet is prefixed with a two-flit Ethernet/Galapagos header. The sequence can be repeated and is spaced by a programmable inter-packet gap. It also sinks and counts the receive stream, so shell loopback runs in hardware or simulation without a DPI packet source.

---
 rtl/eth_packet_player_if.sv | 25 ++
 rtl/eth_packet_player.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_packet_player_if.sv
// AXI-stream bundle used for both the transmit and receive sides of eth_packet_player.
// The master modport drives DATA/KEEP/LAST/VALID; the slave modport drives READY.
interface eth_packet_player_if;
  logic [63:0] DATA;
  logic [7:0]  KEEP;
  logic        LAST;
  logic        VALID;
  logic        READY;

  modport master (
    output DATA,
    output KEEP,
    output LAST,
    output VALID,
    input  READY
  );

  modport slave (
    input  DATA,
    input  KEEP,
    input  LAST,
    input  VALID,
    output READY
  );
endinterface

// File: rtl/eth_packet_player.sv
// eth_packet_player: memory-backed Ethernet stimulus engine for a 64-bit AXI-stream port.
// Plays preloaded flits as packets, each prefixed by a two-flit Ethernet/Galapagos header,
// optionally repeats the sequence, and inserts IPG idle cycles between packets.
// Also sinks the receive stream and counts flits, bytes and packets.
// Optional feature macro: ETH_PLAYER_RX_THROTTLE_EN (rotating receive-ready pattern).
module eth_packet_player #(
  parameter int unsigned DEPTH         = 64,
  parameter int unsigned IPG           = 0,
  parameter logic [47:0] MAC_ADDR_FPGA = 48'hfa163e55ca02,
  parameter logic [47:0] MAC_ADDR_STIM = 48'h0cc47a88c047,
  parameter logic [15:0] ETHERTYPE     = 16'h7400,
  localparam int unsigned AW           = $clog2(DEPTH)
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        load_we,
  input  logic [AW-1:0]               load_addr,
  input  logic [63:0]                 load_data,
  input  logic [7:0]                  load_keep,
  input  logic                        load_last,
  input  logic                        start,
  input  logic [AW:0]                 num_flits,
  input  logic [15:0]                 num_repeat,
  input  logic [7:0]                  dst_id,
  eth_packet_player_if.master         stream_out,
  eth_packet_player_if.slave          stream_in,
  input  logic [7:0]                  throttle_pattern,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 tx_pkt_count,
  output logic [31:0]                 rx_flit_count,
  output logic [31:0]                 rx_byte_count,
  output logic [15:0]                 rx_pkt_count
);

  typedef enum logic [2:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StBody,
    StGap,
    StFin
  } state_e;

  // First header flit: destination MAC then upper source MAC, most significant byte first.
  localparam logic [63:0] Hdr0 = {
    MAC_ADDR_STIM[39:32], MAC_ADDR_STIM[47:40],
    MAC_ADDR_FPGA[7:0],   MAC_ADDR_FPGA[15:8],  MAC_ADDR_FPGA[23:16],
    MAC_ADDR_FPGA[31:24], MAC_ADDR_FPGA[39:32], MAC_ADDR_FPGA[47:40]
  };

  // Gap counter preload; counts down to zero so the idle run is exactly IPG cycles.
  localparam logic [7:0] GapLoad = (IPG > 0) ? 8'(IPG - 1) : 8'd0;

  // Second header flit: lower source MAC, ethertype, Galapagos destination, pad byte.
  function automatic logic [63:0] hdr1(input logic [7:0] dst);
    return {8'h00, dst, ETHERTYPE[7:0], ETHERTYPE[15:8],
            MAC_ADDR_STIM[7:0], MAC_ADDR_STIM[15:8],
            MAC_ADDR_STIM[23:16], MAC_ADDR_STIM[31:24]};
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

  // Flit memory: {last, keep, data}.
  logic [72:0] mem [DEPTH];

  state_e      state_q;
  logic [63:0] data_q;
  logic [7:0]  keep_q;
  logic        last_q;
  logic        valid_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] tx_pkt_count_q;
  logic [AW-1:0] addr_q;
  logic [AW:0] num_flits_q;
  logic [15:0] repeat_q;
  logic [7:0]  dst_id_q;
  logic [7:0]  gap_q;

  logic [31:0] rx_flit_count_q;
  logic [31:0] rx_byte_count_q;
  logic [15:0] rx_pkt_count_q;

  logic          start_ok;
  logic          start_fire;
  logic [AW-1:0] rd_addr;
  logic [72:0]   mem_rd;
  logic [AW:0]   last_idx;
  logic          rd_last;
  logic          pass_end;
  logic          tx_ready;
  logic          rx_ready;
  logic          rx_fire;

  assign start_ok   = (num_flits != '0) && (num_flits <= (AW + 1)'(DEPTH));
  assign start_fire = (state_q == StIdle) && start && start_ok;
  assign tx_ready   = stream_out.READY;

  // In BODY the presented flit is at addr_q, so the next one to fetch is addr_q + 1.
  assign rd_addr  = (state_q == StBody) ? addr_q + AW'(1) : addr_q;
  assign mem_rd   = mem[rd_addr];
  assign last_idx = num_flits_q - (AW + 1)'(1);
  assign rd_last  = ({1'b0, rd_addr} == last_idx);
  assign pass_end = ({1'b0, addr_q} == last_idx);

  // Flit memory write port; loads are locked out while playback is active.
  always_ff @(posedge aclk) begin
    if (load_we && !busy_q) begin
      mem[load_addr] <= {load_last, load_keep, load_data};
    end
  end

  // Playback FSM with registered stream outputs; output regs only advance on a handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= StIdle;
      data_q         <= '0;
      keep_q         <= '0;
      last_q         <= 1'b0;
      valid_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      tx_pkt_count_q <= '0;
      addr_q         <= '0;
      num_flits_q    <= '0;
      repeat_q       <= '0;
      dst_id_q       <= '0;
      gap_q          <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_fire) begin
            num_flits_q    <= num_flits;
            repeat_q       <= num_repeat;
            dst_id_q       <= dst_id;
            tx_pkt_count_q <= '0;
            addr_q         <= '0;
            busy_q         <= 1'b1;
            data_q         <= Hdr0;
            keep_q         <= 8'hff;
            last_q         <= 1'b0;
            valid_q        <= 1'b1;
            state_q        <= StHdr0;
          end
        end
        StHdr0: begin
          if (tx_ready) begin
            data_q  <= hdr1(dst_id_q);
            keep_q  <= 8'hff;
            last_q  <= 1'b0;
            state_q <= StHdr1;
          end
        end
        StHdr1: begin
          if (tx_ready) begin
            data_q  <= mem_rd[63:0];
            keep_q  <= mem_rd[71:64];
            last_q  <= mem_rd[72] | rd_last;
            state_q <= StBody;
          end
        end
        StBody: begin
          if (tx_ready) begin
            if (!last_q) begin
              addr_q <= addr_q + AW'(1);
              data_q <= mem_rd[63:0];
              keep_q <= mem_rd[71:64];
              last_q <= mem_rd[72] | rd_last;
            end else begin
              tx_pkt_count_q <= tx_pkt_count_q + 16'd1;
              if (pass_end && (repeat_q == '0)) begin
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                addr_q  <= '0;
                state_q <= StFin;
              end else begin
                if (pass_end) begin
                  addr_q   <= '0;
                  repeat_q <= repeat_q - 16'd1;
                end else begin
                  addr_q <= addr_q + AW'(1);
                end
                if (IPG > 0) begin
                  valid_q <= 1'b0;
                  gap_q   <= GapLoad;
                  state_q <= StGap;
                end else begin
                  data_q  <= Hdr0;
                  keep_q  <= 8'hff;
                  last_q  <= 1'b0;
                  state_q <= StHdr0;
                end
              end
            end
          end
        end
        StGap: begin
          if (gap_q == '0) begin
            data_q  <= Hdr0;
            keep_q  <= 8'hff;
            last_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= StHdr0;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef ETH_PLAYER_RX_THROTTLE_EN
  logic [7:0] rot_q;
  logic       rot_loaded_q;
  logic [7:0] rot_cur;

  // Until the first clock after reset the pattern input stands in for the rotate register.
  assign rot_cur  = rot_loaded_q ? rot_q : throttle_pattern;
  assign rx_ready = rot_cur[0];

  // Receive-ready rotator, reloaded from the pattern whenever playback starts.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rot_q        <= '0;
      rot_loaded_q <= 1'b0;
    end else begin
      rot_loaded_q <= 1'b1;
      if (start_fire) begin
        rot_q <= throttle_pattern;
      end else begin
        rot_q <= {rot_cur[0], rot_cur[7:1]};
      end
    end
  end
`else
  logic unused_throttle;
  assign unused_throttle = ^throttle_pattern;
  assign rx_ready        = 1'b1;
`endif

  logic unused_rx_data;
  assign unused_rx_data = ^stream_in.DATA;

  assign rx_fire = stream_in.VALID && rx_ready;

  // Receive-side counters; free-running and independent of playback.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_flit_count_q <= '0;
      rx_byte_count_q <= '0;
      rx_pkt_count_q  <= '0;
    end else if (rx_fire) begin
      rx_flit_count_q <= rx_flit_count_q + 32'd1;
      rx_byte_count_q <= rx_byte_count_q + 32'(popcount8(stream_in.KEEP));
      rx_pkt_count_q  <= rx_pkt_count_q + 16'(stream_in.LAST);
    end
  end

  assign stream_out.DATA  = data_q;
  assign stream_out.KEEP  = keep_q;
  assign stream_out.LAST  = last_q;
  assign stream_out.VALID = valid_q;
  assign stream_in.READY  = rx_ready;

  assign busy          = busy_q;
  assign done          = done_q;
  assign tx_pkt_count  = tx_pkt_count_q;
  assign rx_flit_count = rx_flit_count_q;
  assign rx_byte_count = rx_byte_count_q;
  assign rx_pkt_count  = rx_pkt_count_q;

endmodule
